hold_rate_counter: RTL and testbench
====================================

# hold_rate_counter

- Parametrised up/down counter driven by two raw push-buttons.
- Each button is synchronised and debounced. A press steps the count once; holding it auto-repeats, first at a slow rate and then at a fast rate.
- Successor to the single-button hold/transition counter: adds configurable width, down-counting, a two-stage repeat rate, and a wrap-or-saturate limit mode.
- Sits between board buttons (clk domain 100 MHz) and display/consumer logic.

## Interface
- WIDTH, 28: count width in bits.
- MAX_VAL, 2**WIDTH-1: upper count limit; must satisfy MAX_VAL ≤ 2**WIDTH-1.
- DEBOUNCE_CYC, 1_000_000: consecutive stable synchronised samples required to accept a level change; ≥1.
- HOLD1_CYC, 50_000_000: hold cycles after the first step before slow repeat starts.
- HOLD2_CYC, 200_000_000: hold cycles after the first step before fast repeat starts; must be > HOLD1_CYC.
- SLOW_PERIOD, 10_000_000: cycles between steps in SLOW; ≥1.
- FAST_PERIOD, 1_000_000: cycles between steps in FAST; ≥1.
- WRAP, 1: 1 = wrap between 0 and MAX_VAL; 0 = saturate.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- btn_up  in  1  raw, asynchronous up button; active-high.
- btn_down  in  1  raw, asynchronous down button; active-high.
- count  out  WIDTH  current count value.
- phase  out  2  FSM state: 0 IDLE, 1 PRESS, 2 SLOW, 3 FAST.
- step  out  1  one-cycle pulse in the cycle `count` takes a stepped value; pulses even when saturated and unchanged.
- at_limit  out  1  high while `count` == 0 or `count` == MAX_VAL.

## Operation
- Input conditioning, per button:
  - 2-FF synchroniser, then a debounce counter.
  - The debounced level `db_x` flips only after DEBOUNCE_CYC consecutive synchronised samples that differ from the current `db_x`.
  - Any sample equal to `db_x` clears the debounce counter.
- Request decoding:
  - `req` = exactly one of `db_up` or `db_down` is high.
  - Both high is treated as no request.
- FSM state IDLE:
  - A rising `req` steps once in the direction of the pressed button.
  - The direction is latched, `hold_cnt` is cleared to 0, and the FSM moves to PRESS.
- FSM state PRESS:
  - `hold_cnt` increments every cycle.
  - When `hold_cnt` reaches HOLD1_CYC-1: step, clear `rate_cnt`, move to SLOW.
- FSM state SLOW:
  - `hold_cnt` keeps incrementing; `rate_cnt` counts 0..SLOW_PERIOD-1.
  - When `rate_cnt` == SLOW_PERIOD-1: step and clear `rate_cnt`.
  - When `hold_cnt` reaches HOLD2_CYC-1: step, clear `rate_cnt`, move to FAST. The HOLD2 transition takes priority over a coincident slow step; only one step occurs.
- FSM state FAST:
  - Same stepping rule as SLOW, using FAST_PERIOD.
  - `hold_cnt` saturates at HOLD2_CYC-1.
- Exit from PRESS, SLOW or FAST:
  - The FSM returns to IDLE with no step when the latched button releases or the other button also becomes pressed.
  - From IDLE, a new step needs a fresh rising `req`, so releasing one button of a both-pressed pair never causes a step.
- Stepping arithmetic:
  - Up: `count` == MAX_VAL → 0 if WRAP, else hold at MAX_VAL; otherwise +1.
  - Down: `count` == 0 → MAX_VAL if WRAP, else hold at 0; otherwise −1.
  - All comparisons are WIDTH-bit unsigned.
- Counter widths:
  - `hold_cnt` is $clog2(HOLD2_CYC) bits.
  - `rate_cnt` is $clog2(max(SLOW_PERIOD, FAST_PERIOD)) bits, minimum 1.
- Reset (`reset` = 0 at a rising edge) forces:
  - `count`=0, `phase`=0, `step`=0, `at_limit`=1.
  - Synchroniser flops, `db_up` and `db_down` = 0; all internal counters = 0.
  - This applies mid-operation as well: the next press after release of `reset` is handled from IDLE. A button already held at release is accepted as a new press after debounce.

## Timing
- Input to debounced level:
  - 2 cycles through the synchroniser.
  - Then DEBOUNCE_CYC cycles to flip `db_x`.
- First step: `count` and `step` update on the edge after `db_x` rises. Total latency from a clean input edge ≈ DEBOUNCE_CYC+3 cycles.
- Outputs are registered. `step`, `phase` and `at_limit` are coherent with `count` in the same cycle.
- Step timing while held, relative to the first step:
  - Second step at +HOLD1_CYC.
  - Then every SLOW_PERIOD cycles.
  - Step at +HOLD2_CYC.
  - Then every FAST_PERIOD cycles.
- Release: `phase` returns to 0 one cycle after `db_x` falls; no step in that cycle.

## Test plan
Parameters for all scenarios: WIDTH=4, MAX_VAL=9, DEBOUNCE_CYC=4, HOLD1_CYC=20, SLOW_PERIOD=8, HOLD2_CYC=60, FAST_PERIOD=2.

- **Bounce rejection:** pulse btn_up high for 3 cycles, low, high for 3 cycles, then release → `count` stays 0, no `step`.
- **Single press:** btn_up high for 10 cycles → exactly one `step`; `count` 0→1; `phase` goes 1 then 0.
- **Hold profile:** btn_up held for 90 cycles after first step, WRAP=1 → steps at relative cycles 0, 20, 28, 36, 44, 52, 60, 62, 64 …; `phase` goes 1→2→3; `count` wraps 9→0 with `at_limit` high at 9 and at 0.
- **Saturate down:** WRAP=0, `count`=0, hold btn_down for 40 cycles → `step` pulses, `count` stays 0, `at_limit`=1.
- **Both buttons:** press btn_down during an up hold → `phase`=0, no further steps; release btn_down with btn_up still held → no step until btn_up is re-pressed.
- **Reset mid-hold:** assert `reset`=0 for 1 cycle while in FAST with `count`=5 → next cycle `count`=0, `phase`=0, `step`=0, `at_limit`=1.

Source files
------------

// File: rtl/hold_rate_counter.sv
// hold_rate_counter: two-button up/down counter with debounce,
// two-stage auto-repeat and wrap-or-saturate limit handling.
module hold_rate_counter #(
   parameter int WIDTH        = 28,
   parameter int MAX_VAL      = 2**WIDTH-1,
   parameter int DEBOUNCE_CYC = 1_000_000,
   parameter int HOLD1_CYC    = 50_000_000,
   parameter int HOLD2_CYC    = 200_000_000,
   parameter int SLOW_PERIOD  = 10_000_000,
   parameter int FAST_PERIOD  = 1_000_000,
   parameter int WRAP         = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             btn_up,
   input  logic             btn_down,
   output logic [WIDTH-1:0] count,
   output logic [1:0]       phase,
   output logic             step,
   output logic             at_limit
);

   localparam int DB_W     = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam int HOLD_W   = $clog2(HOLD2_CYC);
   localparam int RATE_MAX = (SLOW_PERIOD > FAST_PERIOD) ? SLOW_PERIOD
                                                         : FAST_PERIOD;
   localparam int RATE_W   = (RATE_MAX > 1) ? $clog2(RATE_MAX) : 1;

   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
   localparam logic [HOLD_W-1:0] H1_LAST   = HOLD_W'(HOLD1_CYC - 1);
   localparam logic [HOLD_W-1:0] H2_LAST   = HOLD_W'(HOLD2_CYC - 1);
   localparam logic [RATE_W-1:0] SLOW_LAST = RATE_W'(SLOW_PERIOD - 1);
   localparam logic [RATE_W-1:0] FAST_LAST = RATE_W'(FAST_PERIOD - 1);
   localparam logic [WIDTH-1:0]  MAXV      = WIDTH'(MAX_VAL);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRESS = 2'd1,
      SLOW  = 2'd2,
      FAST  = 2'd3
   } state_e;

   // bit 0 = up button, bit 1 = down button
   logic [1:0]        raw;
   logic [1:0]        s1_q, s2_q;
   logic [1:0]        db_q, db_d;
   logic [DB_W-1:0]   dbc_q [2];
   logic [DB_W-1:0]   dbc_d [2];
   logic              none_q;

   state_e            state_q, state_d;
   logic              dir_q, dir_d;
   logic [HOLD_W-1:0] hold_q, hold_d, hold_inc;
   logic [RATE_W-1:0] rate_q, rate_d;
   logic [WIDTH-1:0]  count_q, count_d;
   logic              step_q, step_d;
   logic              lim_q, lim_d;
   logic              req, held;

   assign raw = {btn_down, btn_up};

   // A level change is accepted only after DEBOUNCE_CYC differing samples
   always_comb begin
      for (int b = 0; b < 2; b++) begin
         db_d[b]  = db_q[b];
         dbc_d[b] = '0;
         if (s2_q[b] != db_q[b]) begin
            if (dbc_q[b] == DB_LAST) begin
               db_d[b] = ~db_q[b];
            end else begin
               dbc_d[b] = dbc_q[b] + DB_W'(1);
            end
         end
      end
   end

   // Synchroniser, debounce and previous-idle registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         s1_q     <= '0;
         s2_q     <= '0;
         db_q     <= '0;
         dbc_q[0] <= '0;
         dbc_q[1] <= '0;
         none_q   <= 1'b0;
      end else begin
         s1_q     <= raw;
         s2_q     <= s1_q;
         db_q     <= db_d;
         dbc_q[0] <= dbc_d[0];
         dbc_q[1] <= dbc_d[1];
         none_q   <= ~db_q[0] & ~db_q[1];
      end
   end

   // A fresh press requires both buttons released in the previous cycle,
   // so letting go of one of a pressed pair never looks like a press.
   assign req      = db_q[0] ^ db_q[1];
   assign held     = req & (dir_q ? db_q[0] : db_q[1]);
   assign hold_inc = (hold_q == H2_LAST) ? hold_q : hold_q + HOLD_W'(1);

   // Next-state, repeat timing and step decision
   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      hold_d  = hold_q;
      rate_d  = rate_q;
      step_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            hold_d = '0;
            rate_d = '0;
            if (req && none_q) begin
               step_d  = 1'b1;
               dir_d   = db_q[0];
               state_d = PRESS;
            end
         end
         PRESS: begin
            if (!held) begin
               state_d = IDLE;
            end else begin
               hold_d = hold_inc;
               if (hold_q == H1_LAST) begin
                  step_d  = 1'b1;
                  rate_d  = '0;
                  state_d = SLOW;
               end
            end
         end
         SLOW: begin
            if (!held) begin
               state_d = IDLE;
            end else begin
               hold_d = hold_inc;
               if (hold_q == H2_LAST) begin
                  step_d  = 1'b1;
                  rate_d  = '0;
                  state_d = FAST;
               end else if (rate_q == SLOW_LAST) begin
                  step_d = 1'b1;
                  rate_d = '0;
               end else begin
                  rate_d = rate_q + RATE_W'(1);
               end
            end
         end
         FAST: begin
            if (!held) begin
               state_d = IDLE;
            end else begin
               hold_d = hold_inc;
               if (rate_q == FAST_LAST) begin
                  step_d = 1'b1;
                  rate_d = '0;
               end else begin
                  rate_d = rate_q + RATE_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Step arithmetic with wrap or saturate at the limits
   always_comb begin
      count_d = count_q;
      if (step_d) begin
         if (dir_d) begin
            if (count_q == MAXV) begin
               count_d = (WRAP != 0) ? '0 : MAXV;
            end else begin
               count_d = count_q + WIDTH'(1);
            end
         end else begin
            if (count_q == '0) begin
               count_d = (WRAP != 0) ? MAXV : '0;
            end else begin
               count_d = count_q - WIDTH'(1);
            end
         end
      end
      lim_d = (count_d == '0) || (count_d == MAXV);
   end

   // FSM, counters and registered outputs
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         dir_q   <= 1'b0;
         hold_q  <= '0;
         rate_q  <= '0;
         count_q <= '0;
         step_q  <= 1'b0;
         lim_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         hold_q  <= hold_d;
         rate_q  <= rate_d;
         count_q <= count_d;
         step_q  <= step_d;
         lim_q   <= lim_d;
      end
   end

   assign count    = count_q;
   assign phase    = state_q;
   assign step     = step_q;
   assign at_limit = lim_q;

endmodule

// File: tb/tb_hold_rate_counter.sv
// tb_hold_rate_counter: wrap and saturate instances checked each cycle
// against a timeline model of press, hold and repeat behaviour.
module tb_hold_rate_counter;

   localparam int W  = 4;
   localparam int MX = 9;
   localparam int DB = 4;
   localparam int H1 = 20;
   localparam int H2 = 60;
   localparam int SP = 8;
   localparam int FP = 2;

   typedef struct {
      int         cyc;
      logic [3:0] cnt;
      logic [1:0] ph;
      logic       st;
      logic       lim;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       btn_up;
   logic       btn_down;
   logic [3:0] c0, c1;
   logic [1:0] p0, p1;
   logic       s0, s1, l0, l1;

   int errs   = 0;
   int checks = 0;

   exp_t q0[$];
   exp_t q1[$];

   always #5 clk = ~clk;

   hold_rate_counter #(
      .WIDTH(W), .MAX_VAL(MX), .DEBOUNCE_CYC(DB),
      .HOLD1_CYC(H1), .HOLD2_CYC(H2),
      .SLOW_PERIOD(SP), .FAST_PERIOD(FP), .WRAP(1)
   ) u_wrap (
      .clk(clk), .reset(reset),
      .btn_up(btn_up), .btn_down(btn_down),
      .count(c0), .phase(p0), .step(s0), .at_limit(l0)
   );

   hold_rate_counter #(
      .WIDTH(W), .MAX_VAL(MX), .DEBOUNCE_CYC(DB),
      .HOLD1_CYC(H1), .HOLD2_CYC(H2),
      .SLOW_PERIOD(SP), .FAST_PERIOD(FP), .WRAP(0)
   ) u_sat (
      .clk(clk), .reset(reset),
      .btn_up(btn_up), .btn_down(btn_down),
      .count(c1), .phase(p1), .step(s1), .at_limit(l1)
   );

   // Reference model: delayed samples, window debounce, and step times
   // derived from the elapsed time since the first step of a hold.
   int cyc = 0;
   bit ru[$], rd[$], hu[$], hd[$];
   bit dbu, dbd, none_b;
   bit act [2];
   bit dir [2];
   int t0  [2];
   int cm  [2];

   task automatic model_fsm(int i, bit u, bit d, bit nb);
      bit   req;
      bit   s;
      int   t;
      int   ph;
      exp_t e;
      req = u ^ d;
      s   = 0;
      ph  = 0;
      if (!act[i]) begin
         if (req && nb) begin
            act[i] = 1;
            dir[i] = u;
            t0[i]  = cyc;
            s      = 1;
            ph     = 1;
         end
      end else if (!(req && (dir[i] ? u : d))) begin
         act[i] = 0;
      end else begin
         t  = cyc - t0[i];
         s  = (t == H1) || (t == H2) ||
              (t > H1 && t < H2 && (t - H1) % SP == 0) ||
              (t > H2 && (t - H2) % FP == 0);
         ph = (t < H1) ? 1 : (t < H2) ? 2 : 3;
      end
      if (s) begin
         if (dir[i]) cm[i] = (cm[i] == MX) ? ((i == 0) ? 0 : MX) : cm[i] + 1;
         else        cm[i] = (cm[i] == 0) ? ((i == 0) ? MX : 0) : cm[i] - 1;
      end
      e.cyc = cyc;
      e.cnt = 4'(cm[i]);
      e.ph  = 2'(ph);
      e.st  = s;
      e.lim = (cm[i] == 0) || (cm[i] == MX);
      if (i == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   always @(posedge clk) begin
      exp_t e;
      bit   du, dd, ou, od, f;
      cyc++;
      if (!reset) begin
         ru.delete(); rd.delete(); hu.delete(); hd.delete();
         ru.push_back(0); ru.push_back(0);
         rd.push_back(0); rd.push_back(0);
         dbu = 0; dbd = 0; none_b = 0;
         for (int i = 0; i < 2; i++) begin
            act[i] = 0;
            cm[i]  = 0;
         end
         e.cyc = cyc; e.cnt = 0; e.ph = 0; e.st = 0; e.lim = 1;
         q0.push_back(e);
         q1.push_back(e);
      end else begin
         du = ru.pop_front(); ru.push_back(btn_up);
         dd = rd.pop_front(); rd.push_back(btn_down);
         ou = dbu;
         od = dbd;
         model_fsm(0, ou, od, none_b);
         model_fsm(1, ou, od, none_b);
         none_b = !ou && !od;
         hu.push_back(du);
         if (hu.size() > DB) void'(hu.pop_front());
         if (hu.size() == DB) begin
            f = 1;
            foreach (hu[j]) if (hu[j] == dbu) f = 0;
            if (f) dbu = !dbu;
         end
         hd.push_back(dd);
         if (hd.size() > DB) void'(hd.pop_front());
         if (hd.size() == DB) begin
            f = 1;
            foreach (hd[j]) if (hd[j] == dbd) f = 0;
            if (f) dbd = !dbd;
         end
      end
   end

   task automatic cmp(int i, exp_t e, logic [3:0] c, logic [1:0] p,
                      logic s, logic l);
      checks++;
      if (c !== e.cnt || p !== e.ph || s !== e.st || l !== e.lim) begin
         errs++;
         if (errs <= 40)
            $display("FAIL snap inst%0d cyc%0d: got cnt=%0d ph=%0d st=%0d lim=%0d want cnt=%0d ph=%0d st=%0d lim=%0d",
                     i, e.cyc, c, p, s, l, e.cnt, e.ph, e.st, e.lim);
      end
   endtask

   // Monitor: every cycle the DUT presents a registered snapshot
   always @(negedge clk) begin
      exp_t e;
      if (q0.size() > 0) begin
         e = q0.pop_front();
         cmp(0, e, c0, p0, s0, l0);
      end
      if (q1.size() > 0) begin
         e = q1.pop_front();
         cmp(1, e, c1, p1, s1, l1);
      end
   end

   task automatic chk(string nm, int got, int want);
      checks++;
      if (got != want) begin
         errs++;
         $display("FAIL %s: got %0d want %0d", nm, got, want);
      end
   endtask

   task automatic run(int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      bit hit;
      reset    = 1'b0;
      btn_up   = 1'b0;
      btn_down = 1'b0;
      run(3);
      chk("reset_count", c0, 0);
      chk("reset_limit", l0, 1);
      reset = 1'b1;
      run(2);

      // bounce shorter than the debounce window
      btn_up = 1; run(3); btn_up = 0; run(2);
      btn_up = 1; run(3); btn_up = 0; run(20);
      chk("bounce_count", c0, 0);

      // single short press
      btn_up = 1; run(10); btn_up = 0; run(20);
      chk("single_count_wrap", c0, 1);
      chk("single_count_sat", c1, 1);

      // long hold through slow into fast repeat
      btn_up = 1; run(100);
      chk("hold_phase_fast", p0, 3);
      btn_up = 0; run(20);
      chk("release_phase", p0, 0);

      // saturate down from zero on the non-wrapping instance
      reset = 0; run(1); reset = 1; run(2);
      btn_down = 1; run(50);
      chk("sat_count", c1, 0);
      chk("sat_limit", l1, 1);
      chk("sat_phase_slow", p1, 2);
      btn_down = 0; run(20);

      // both buttons: cancel, then half-release must not step
      btn_up = 1; run(35);
      btn_down = 1; run(12);
      chk("both_phase", p0, 0);
      btn_down = 0; run(15);
      chk("half_release_phase", p0, 0);
      btn_up = 0; run(15);
      btn_up = 1; run(12);
      chk("repress_phase", p0, 1);
      btn_up = 0; run(20);

      // reset while in fast repeat at count 5
      btn_up = 1;
      hit = 0;
      for (int i = 0; i < 300 && !hit; i++) begin
         run(1);
         if (p0 == 2'd3 && c0 == 4'd5) hit = 1;
      end
      chk("reach_fast_5", int'(hit), 1);
      reset = 0; run(1);
      chk("midrst_count", c0, 0);
      chk("midrst_phase", p0, 0);
      chk("midrst_step", s0, 0);
      chk("midrst_limit", l0, 1);
      reset = 1; run(30);
      btn_up = 0; run(20);

      // random button activity with occasional resets
      for (int k = 0; k < 40; k++) begin
         btn_up   = 1'($urandom_range(0, 1));
         btn_down = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 19) == 0) reset = 0;
         run(1);
         reset = 1;
         run($urandom_range(1, 90));
      end
      btn_up = 0; btn_down = 0; run(20);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
